// File: rtl/wb_collect_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_collect_pkg : shared writeback entry type and constants.  Rev 1.0
// ---------------------------------------------------------------------------
package wb_collect_pkg;

   localparam int PKG_REG_W = 5;
   localparam logic [PKG_REG_W-1:0] ZERO_REG = 5'd31;

   localparam int UNIT_LOG   = 0;
   localparam int UNIT_SHIFT = 1;
   localparam int UNIT_ADD   = 2;
   localparam int UNIT_MUL   = 3;

   typedef struct packed {
      logic [63:0]          result;
      logic                 cmp;
      logic                 is_cmov;
      logic [PKG_REG_W-1:0] dest;
   } wb_entry_t;

   // A failed CMOV retires without writing; R31 is the architectural sink.
   function automatic logic entry_writes(input wb_entry_t e);
      return ~(e.is_cmov & ~e.cmp) & (e.dest != ZERO_REG);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_collect_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_fifo : fall-through FIFO of writeback entries with wrap-bit pointers.
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_fifo
   import wb_collect_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  wb_entry_t                   din,
   input  logic                        pop,
   output wb_entry_t                   dout,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] ONE = 1;

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] occ;
   logic        wr_en;
   logic        rd_en;
   wb_entry_t   mem [FIFO_DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign occ   = wr_ptr - rd_ptr;

   // When empty, a same-cycle push+pop passes straight through without storage.
   assign dout  = empty ? din : mem[rd_ptr[AW-1:0]];
   assign wr_en = push & ~(empty & pop) & (~full | pop);
   assign rd_en = pop & ~empty;

   // Occupancy after this cycle's update, used for registered flow control.
   assign count = occ + (wr_en ? ONE : '0) - (rd_en ? ONE : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ONE;
         if (rd_en) rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/wb_collect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_collect : per-unit result FIFOs, round-robin onto one RF write port.
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_collect
   import wb_collect_pkg::*;
#(
   parameter int NUM_UNITS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int REG_W      = 5
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_UNITS-1:0]                  u_rvalid,
   input  logic [NUM_UNITS-1:0][63:0]            u_result,
   input  logic [NUM_UNITS-1:0]                  u_cmp,
   input  logic [NUM_UNITS-1:0]                  u_is_cmov,
   input  logic [NUM_UNITS-1:0][REG_W-1:0]       u_dest,
   output logic [NUM_UNITS-1:0]                  u_ready,
   output logic                                  rf_we,
   output logic [REG_W-1:0]                      rf_waddr,
   output logic [63:0]                           rf_wdata,
   output logic                                  retire_valid,
   output logic [$clog2(NUM_UNITS)-1:0]          retire_unit,
   output logic                                  overflow_err
);

   localparam int UW = $clog2(NUM_UNITS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [UW-1:0] LAST_UNIT = UW'(NUM_UNITS - 1);
   localparam logic [AW:0]   READY_MAX = (AW + 1)'(FIFO_DEPTH - 2);

   wb_entry_t              din   [NUM_UNITS];
   wb_entry_t              dout  [NUM_UNITS];
   logic [AW:0]            cnt   [NUM_UNITS];
   logic [NUM_UNITS-1:0]   empty;
   logic [NUM_UNITS-1:0]   full;
   logic [NUM_UNITS-1:0]   avail;
   logic [NUM_UNITS-1:0]   pop;
   logic [NUM_UNITS-1:0]   drop;

   logic [UW-1:0]          rr_ptr;
   logic                   sel_valid;
   logic [UW-1:0]          sel_idx;
   wb_entry_t              sel_entry;

   generate
      for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
         assign din[i].result  = u_result[i];
         assign din[i].cmp     = u_cmp[i];
         assign din[i].is_cmov = u_is_cmov[i];
         assign din[i].dest    = u_dest[i];

         // Fall-through makes a fresh push eligible in the cycle it arrives.
         assign avail[i] = ~empty[i] | u_rvalid[i];
         assign pop[i]   = sel_valid && (sel_idx == UW'(i));
         assign drop[i]  = u_rvalid[i] & full[i] & ~pop[i];

         wb_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (u_rvalid[i]),
            .din   (din[i]),
            .pop   (pop[i]),
            .dout  (dout[i]),
            .empty (empty[i]),
            .full  (full[i]),
            .count (cnt[i])
         );
      end
   endgenerate

   always_comb begin
      int j;
      sel_valid = 1'b0;
      sel_idx   = '0;
      j         = 0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_UNITS) j = j - NUM_UNITS;
         if (!sel_valid && avail[j]) begin
            sel_valid = 1'b1;
            sel_idx   = UW'(j);
         end
      end
   end

   assign sel_entry = dout[sel_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr       <= '0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         retire_valid <= 1'b0;
         retire_unit  <= '0;
         overflow_err <= 1'b0;
         u_ready      <= '1;
      end else begin
         if (sel_valid) begin
            rr_ptr       <= (sel_idx == LAST_UNIT) ? '0 : sel_idx + 1'b1;
            retire_valid <= 1'b1;
            retire_unit  <= sel_idx;
            rf_we        <= entry_writes(sel_entry);
            rf_waddr     <= sel_entry.dest;
            rf_wdata     <= sel_entry.result;
         end else begin
            retire_valid <= 1'b0;
            rf_we        <= 1'b0;
         end
         overflow_err <= overflow_err | (|drop);
         for (int i = 0; i < NUM_UNITS; i++) begin
            u_ready[i] <= (cnt[i] <= READY_MAX);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_collect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_collect : directed self-checking bench for wb_collect.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_collect;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int RW = 5;

   logic                 clk;
   logic                 reset;
   logic [N-1:0]         u_rvalid;
   logic [N-1:0][63:0]   u_result;
   logic [N-1:0]         u_cmp;
   logic [N-1:0]         u_is_cmov;
   logic [N-1:0][RW-1:0] u_dest;
   logic [N-1:0]         u_ready;
   logic                 rf_we;
   logic [RW-1:0]        rf_waddr;
   logic [63:0]          rf_wdata;
   logic                 retire_valid;
   logic [1:0]           retire_unit;
   logic                 overflow_err;

   int vectors     = 0;
   int miscompares = 0;
   int k2          = 0;
   bit mon_u2      = 1'b0;
   logic [63:0] exp_u2 [5];

   wb_collect #(
      .NUM_UNITS  (N),
      .FIFO_DEPTH (D),
      .REG_W      (RW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .u_rvalid     (u_rvalid),
      .u_result     (u_result),
      .u_cmp        (u_cmp),
      .u_is_cmov    (u_is_cmov),
      .u_dest       (u_dest),
      .u_ready      (u_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .retire_valid (retire_valid),
      .retire_unit  (retire_unit),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Unit 2 retirements are tracked in order while the overflow scenario runs.
   task automatic tick();
      @(posedge clk);
      #1;
      if (mon_u2 && retire_valid && retire_unit == 2'd2) begin
         if (k2 < 5) check("u2_order", rf_wdata, exp_u2[k2]);
         k2++;
      end
   endtask

   task automatic clear_in();
      u_rvalid  = '0;
      u_result  = '0;
      u_cmp     = '0;
      u_is_cmov = '0;
      u_dest    = '0;
   endtask

   task automatic set_unit(input int i, input logic [63:0] r, input logic c,
                           input logic m, input logic [RW-1:0] d);
      u_rvalid[i]  = 1'b1;
      u_result[i]  = r;
      u_cmp[i]     = c;
      u_is_cmov[i] = m;
      u_dest[i]    = d;
   endtask

   initial begin
      reset = 1'b1;
      clear_in();
      tick();
      tick();
      check("rst_we",    64'(rf_we), 0);
      check("rst_waddr", 64'(rf_waddr), 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_rv",    64'(retire_valid), 0);
      check("rst_unit",  64'(retire_unit), 0);
      check("rst_ovf",   64'(overflow_err), 0);
      check("rst_ready", 64'(u_ready), 64'hF);
      reset = 1'b0;
      tick();
      check("idle_rv", 64'(retire_valid), 0);

      // single write from unit 0
      set_unit(0, 64'h1234, 1'b0, 1'b0, 5'd3);
      tick();
      clear_in();
      check("single_we",    64'(rf_we), 1);
      check("single_waddr", 64'(rf_waddr), 3);
      check("single_wdata", rf_wdata, 64'h1234);
      check("single_rv",    64'(retire_valid), 1);
      check("single_unit",  64'(retire_unit), 0);
      tick();
      check("single_rv_off", 64'(retire_valid), 0);
      check("single_we_off", 64'(rf_we), 0);

      // CMOV false then true
      set_unit(0, 64'h55, 1'b0, 1'b1, 5'd7);
      tick();
      clear_in();
      check("cmov0_rv", 64'(retire_valid), 1);
      check("cmov0_we", 64'(rf_we), 0);
      set_unit(0, 64'hFF, 1'b1, 1'b1, 5'd7);
      tick();
      clear_in();
      check("cmov1_we",    64'(rf_we), 1);
      check("cmov1_waddr", 64'(rf_waddr), 7);
      check("cmov1_wdata", rf_wdata, 64'hFF);

      // R31 sink from unit 3; pointer returns to 0 afterwards
      set_unit(3, 64'hDEAD, 1'b0, 1'b0, 5'd31);
      tick();
      clear_in();
      check("r31_rv",   64'(retire_valid), 1);
      check("r31_we",   64'(rf_we), 0);
      check("r31_unit", 64'(retire_unit), 3);

      // two simultaneous bursts, each retiring 0,1,2,3
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < N; i++) set_unit(i, 64'(10 * (b + 1) + i), 1'b0, 1'b0, RW'(i + 1));
         for (int k = 0; k < N; k++) begin
            tick();
            clear_in();
            check("burst_unit",  64'(retire_unit), 64'(k));
            check("burst_wdata", rf_wdata, 64'(10 * (b + 1) + k));
            check("burst_waddr", 64'(rf_waddr), 64'(k + 1));
            check("burst_we",    64'(rf_we), 1);
         end
      end
      tick();
      check("burst_done", 64'(retire_valid), 0);

      // overflow: every unit pushes each cycle, unit 2 wins 1 in 4
      for (int c = 0; c < 5; c++) exp_u2[c] = 64'h300 + 64'(c);
      k2     = 0;
      mon_u2 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) set_unit(i, 64'h100 * 64'(i + 1) + 64'(c), 1'b0, 1'b0, RW'(i + 1));
         tick();
         if (c == 2) check("ready2_cnt2", 64'(u_ready[2]), 1);
         if (c == 3) check("ready2_cnt3", 64'(u_ready[2]), 0);
         if (c == 4) check("ovf_at_full", 64'(overflow_err), 0);
         if (c == 5) check("ovf_set",     64'(overflow_err), 1);
      end
      clear_in();
      repeat (20) tick();
      mon_u2 = 1'b0;
      check("u2_count",    64'(k2), 5);
      check("ovf_sticky",  64'(overflow_err), 1);
      check("drain_ready", 64'(u_ready), 64'hF);
      check("drain_rv",    64'(retire_valid), 0);

      // reset mid-operation with three entries buffered
      for (int i = 0; i < N; i++) set_unit(i, 64'hA0 + 64'(i), 1'b0, 1'b0, RW'(i + 1));
      tick();
      clear_in();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_we",    64'(rf_we), 0);
      check("mrst_rv",    64'(retire_valid), 0);
      check("mrst_ready", 64'(u_ready), 64'hF);
      check("mrst_ovf",   64'(overflow_err), 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("mrst_stale", 64'(retire_valid), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
